// File: rtl/option_router.sv
// Routes parser and solver lines into the row/column option FIFOs and tracks their occupancy.
// Define ROUTER_STATS_EN to build the per-FIFO peak occupancy registers (peak_r/peak_c read 0 otherwise).
module option_router #(
  parameter  int LINE_WIDTH = 16,
  parameter  int FIFO_DEPTH = 1024,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  parse_write,
  input  logic [LINE_WIDTH-1:0] parse_line,
  input  logic                  parse_row,
  input  logic                  parsed,
  input  logic                  solve_write_r,
  input  logic                  solve_write_c,
  input  logic [LINE_WIDTH-1:0] solve_line_r,
  input  logic [LINE_WIDTH-1:0] solve_line_c,
  input  logic                  solve_read_r,
  input  logic                  solve_read_c,
  input  logic                  solved,
  input  logic                  fifo_full_r,
  input  logic                  fifo_full_c,
  output logic                  fifo_write_r,
  output logic                  fifo_write_c,
  output logic [LINE_WIDTH-1:0] fifo_in_r,
  output logic [LINE_WIDTH-1:0] fifo_in_c,
  output logic                  fifo_flush,
  output logic [CNT_W-1:0]      count_r,
  output logic [CNT_W-1:0]      count_c,
  output logic [1:0]            state,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  stray,
  output logic [CNT_W-1:0]      peak_r,
  output logic [CNT_W-1:0]      peak_c
);

  typedef enum logic [1:0] {
    RECEIVE = 2'd0,
    SOLVE   = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t state_reg;
  logic   fifo_flush_reg;
  logic   overflow_reg, underflow_reg, stray_reg;

  logic in_receive, in_solve, in_flush, flush_start;
  assign in_receive  = (state_reg == RECEIVE);
  assign in_solve    = (state_reg == SOLVE);
  assign in_flush    = (state_reg == FLUSH);
  assign flush_start = in_solve && solved;

  // Index 0 is the row FIFO, index 1 the column FIFO.
  logic [1:0]            req, full, rd, drop, under;
  logic [LINE_WIDTH-1:0] line_sel [2];

  assign req[0] = (in_receive && parse_write && parse_row)
                | (in_solve && solve_write_r && !solved);
  assign req[1] = (in_receive && parse_write && !parse_row)
                | (in_solve && solve_write_c && !solved);
  assign line_sel[0] = in_receive ? parse_line : solve_line_r;
  assign line_sel[1] = in_receive ? parse_line : solve_line_c;
  assign full = {fifo_full_c, fifo_full_r};
  assign rd   = {solve_read_c, solve_read_r} & {2{!in_flush}};

  logic [CNT_W-1:0]      count_q [2];
  logic [CNT_W-1:0]      peak_q  [2];
  logic [1:0]            wr_q;
  logic [LINE_WIDTH-1:0] din_q   [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  accept;
    logic                  wr_reg;
    logic [LINE_WIDTH-1:0] din_reg;

    always_comb begin
      accept     = req[gi] && !full[gi] && (count_reg < CNT_W'(FIFO_DEPTH));
      count_next = count_reg;
      if (accept && !rd[gi])
        count_next = count_reg + 1'b1;
      else if (!accept && rd[gi] && (count_reg != '0))
        count_next = count_reg - 1'b1;
    end

    assign drop[gi]  = req[gi] && !accept;
    assign under[gi] = rd[gi] && (count_reg == '0);

    always_ff @(posedge clk) begin
      if (rst) begin
        count_reg <= '0;
        wr_reg    <= 1'b0;
        din_reg   <= '0;
      end else begin
        wr_reg <= accept;
        if (accept)
          din_reg <= line_sel[gi];
        // Entering FLUSH clears occupancy so the flush cycle already reports empty FIFOs.
        count_reg <= flush_start ? '0 : count_next;
      end
    end

`ifdef ROUTER_STATS_EN
    logic [CNT_W-1:0] peak_reg;
    always_ff @(posedge clk) begin
      if (rst)
        peak_reg <= '0;
      else if (flush_start)
        peak_reg <= '0;
      else if (count_next > peak_reg)
        peak_reg <= count_next;
    end
    assign peak_q[gi] = peak_reg;
`else
    assign peak_q[gi] = '0;
`endif

    assign count_q[gi] = count_reg;
    assign wr_q[gi]    = wr_reg;
    assign din_q[gi]   = din_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RECEIVE;
      fifo_flush_reg <= 1'b0;
    end else begin
      fifo_flush_reg <= 1'b0;
      case (state_reg)
        RECEIVE: if (parsed) state_reg <= SOLVE;
        SOLVE: begin
          if (solved) begin
            state_reg      <= FLUSH;
            fifo_flush_reg <= 1'b1;
          end
        end
        FLUSH:   state_reg <= RECEIVE;
        default: state_reg <= RECEIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      stray_reg     <= 1'b0;
    end else begin
      overflow_reg  <= overflow_reg  | (|drop);
      underflow_reg <= underflow_reg | (|under);
      stray_reg     <= stray_reg
                     | (parse_write && !in_receive)
                     | ((solve_write_r || solve_write_c) && !in_solve);
    end
  end

  assign fifo_write_r = wr_q[0];
  assign fifo_write_c = wr_q[1];
  assign fifo_in_r    = din_q[0];
  assign fifo_in_c    = din_q[1];
  assign fifo_flush   = fifo_flush_reg;
  assign count_r      = count_q[0];
  assign count_c      = count_q[1];
  assign peak_r       = peak_q[0];
  assign peak_c       = peak_q[1];
  assign state        = state_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;
  assign stray        = stray_reg;

endmodule

// File: tb/tb_option_router.sv
// Directed bench for option_router: expected FIFO writes are queued at drive time and popped on wr_en.
module tb_option_router;
  localparam int LW = 16;
  localparam int CW = $clog2(1024 + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          parse_write = 1'b0, parse_row = 1'b0, parsed = 1'b0;
  logic [LW-1:0] parse_line = '0;
  logic          solve_write_r = 1'b0, solve_write_c = 1'b0;
  logic [LW-1:0] solve_line_r = '0, solve_line_c = '0;
  logic          solve_read_r = 1'b0, solve_read_c = 1'b0, solved = 1'b0;
  logic          fifo_full_r = 1'b0, fifo_full_c = 1'b0;
  logic          fifo_write_r, fifo_write_c, fifo_flush;
  logic [LW-1:0] fifo_in_r, fifo_in_c;
  logic [CW-1:0] count_r, count_c, peak_r, peak_c;
  logic [1:0]    state;
  logic          overflow, underflow, stray;

  int checks = 0;
  int failures = 0;
  logic [31:0] q_r [$];
  logic [31:0] q_c [$];
  logic [31:0] exp_peak;

  option_router dut (
    .clk(clk), .rst(rst),
    .parse_write(parse_write), .parse_line(parse_line), .parse_row(parse_row), .parsed(parsed),
    .solve_write_r(solve_write_r), .solve_write_c(solve_write_c),
    .solve_line_r(solve_line_r), .solve_line_c(solve_line_c),
    .solve_read_r(solve_read_r), .solve_read_c(solve_read_c), .solved(solved),
    .fifo_full_r(fifo_full_r), .fifo_full_c(fifo_full_c),
    .fifo_write_r(fifo_write_r), .fifo_write_c(fifo_write_c),
    .fifo_in_r(fifo_in_r), .fifo_in_c(fifo_in_c), .fifo_flush(fifo_flush),
    .count_r(count_r), .count_c(count_c), .state(state),
    .overflow(overflow), .underflow(underflow), .stray(stray),
    .peak_r(peak_r), .peak_c(peak_c)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic parse_wr(input logic row, input logic [LW-1:0] data);
    parse_write = 1'b1; parse_row = row; parse_line = data;
    if (row) q_r.push_back({16'h0, data}); else q_c.push_back({16'h0, data});
    tick();
    parse_write = 1'b0;
    $display("parse_write row=%0b data=%04h count_r=%0d count_c=%0d", row, data, count_r, count_c);
  endtask

  task automatic read_r();
    solve_read_r = 1'b1;
    tick();
    solve_read_r = 1'b0;
    $display("solve_read_r count_r=%0d underflow=%0b", count_r, underflow);
  endtask

  // Scoreboard: every wr_en pulse must match the oldest expected line (0xFFFFFFFF = nothing expected).
  always @(negedge clk) begin
    logic [31:0] e;
    if (fifo_write_r === 1'b1) begin
      e = (q_r.size() > 0) ? q_r.pop_front() : 32'hFFFF_FFFF;
      check("fifo_in_r", {16'h0, fifo_in_r}, e);
      $display("row fifo write data=%04h", fifo_in_r);
    end
    if (fifo_write_c === 1'b1) begin
      e = (q_c.size() > 0) ? q_c.pop_front() : 32'hFFFF_FFFF;
      check("fifo_in_c", {16'h0, fifo_in_c}, e);
      $display("col fifo write data=%04h", fifo_in_c);
    end
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("reset_state", 32'(state), 0);
    check("reset_count_r", 32'(count_r), 0);
    check("reset_wr_r", 32'(fifo_write_r), 0);
    check("reset_in_c", 32'(fifo_in_c), 0);
    check("reset_flush", 32'(fifo_flush), 0);
    check("reset_flags", {29'h0, overflow, underflow, stray}, 0);
    check("reset_peak_r", 32'(peak_r), 0);

    parse_wr(1'b1, 16'h0003);
    parse_wr(1'b1, 16'h0011);
    parse_wr(1'b0, 16'h0005);
    parse_wr(1'b1, 16'h0022);
    parse_wr(1'b0, 16'h0040);
    tick();
    check("rx_count_r", 32'(count_r), 3);
    check("rx_count_c", 32'(count_c), 2);
    check("rx_state", 32'(state), 0);

    parsed = 1'b1;
    parse_wr(1'b1, 16'h0077);
    parsed = 1'b0;
    check("parsed_state", 32'(state), 1);
    check("parsed_count_r", 32'(count_r), 4);

    read_r();
    check("read_count_r", 32'(count_r), 3);
    solve_write_r = 1'b1; solve_line_r = 16'h0100; solve_read_r = 1'b1;
    q_r.push_back(32'h0100);
    tick();
    solve_write_r = 1'b0; solve_read_r = 1'b0;
    $display("solve_write_r+read data=0100 count_r=%0d", count_r);
    check("rw_count_r", 32'(count_r), 3);

    read_r(); read_r(); read_r();
    check("drain_count_r", 32'(count_r), 0);
    check("drain_underflow", 32'(underflow), 0);
    read_r();
    check("under_count_r", 32'(count_r), 0);
    check("under_flag", 32'(underflow), 1);

    fifo_full_c = 1'b1; solve_write_c = 1'b1; solve_line_c = 16'h0ABC;
    tick();
    fifo_full_c = 1'b0; solve_write_c = 1'b0;
    $display("solve_write_c while full count_c=%0d overflow=%0b", count_c, overflow);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_count_c", 32'(count_c), 2);

    solve_write_r = 1'b1; solve_line_r = 16'h0200;
    solve_write_c = 1'b1; solve_line_c = 16'h0300;
    q_r.push_back(32'h0200); q_c.push_back(32'h0300);
    tick();
    solve_write_r = 1'b0; solve_write_c = 1'b0;
    $display("dual solve write count_r=%0d count_c=%0d", count_r, count_c);
    check("dual_count_r", 32'(count_r), 1);
    check("dual_count_c", 32'(count_c), 3);

    check("stray_before", 32'(stray), 0);
    parse_write = 1'b1; parse_row = 1'b1; parse_line = 16'h0999;
    tick();
    parse_write = 1'b0;
    $display("parse_write in SOLVE stray=%0b", stray);
    check("stray_flag", 32'(stray), 1);
    check("stray_count_r", 32'(count_r), 1);

    solved = 1'b1; solve_write_r = 1'b1; solve_line_r = 16'h0BAD;
    tick();
    solved = 1'b0; solve_write_r = 1'b0;
    $display("solved state=%0d flush=%0b", state, fifo_flush);
    check("flush_state", 32'(state), 2);
    check("flush_pulse", 32'(fifo_flush), 1);
    check("flush_count_r", 32'(count_r), 0);
    check("flush_count_c", 32'(count_c), 0);
    tick();
    check("post_flush_state", 32'(state), 0);
    check("post_flush_pulse", 32'(fifo_flush), 0);
    check("sticky_flags", {29'h0, overflow, underflow, stray}, 32'h7);

    for (int i = 0; i < 5; i++) parse_wr(1'b1, LW'(16'h1000 + i));
    read_r(); read_r();
    parse_wr(1'b1, 16'h2000);
`ifdef ROUTER_STATS_EN
    exp_peak = 5;
`else
    exp_peak = 0;
`endif
    check("peak_count_r", 32'(count_r), 4);
    check("peak_r", 32'(peak_r), exp_peak);

    tick(); tick();
    check("sb_empty_r", 32'(q_r.size()), 0);
    check("sb_empty_c", 32'(q_c.size()), 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("mid-op reset state=%0d count_r=%0d", state, count_r);
    check("rst_count_r", 32'(count_r), 0);
    check("rst_flags", {29'h0, overflow, underflow, stray}, 0);
    check("rst_flush", 32'(fifo_flush), 0);
    check("rst_state", 32'(state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
